// File: rtl/menu_param_editor.sv
// Menu parameter bank with browse/edit/commit flow, driven by the push-button adapter's
// absolute cursor and Okay/Cancel buttons; writes committed values out over a req/ack handshake.
module menu_param_editor #(
  parameter int unsigned MAX_CURSOR_INDEX = 10,
  parameter int unsigned DATA_W           = 8,
  parameter int unsigned VAL_MAX          = 255,
  parameter int unsigned INIT_VAL         = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        iCursor_Index,
  input  logic [1:0]        iOkayCancel,
  input  logic              iWr_Ack,
  input  logic [3:0]        iDisp_Index,
  output logic [DATA_W-1:0] oDisp_Value,
  output logic [3:0]        oSel_Index,
  output logic              oEdit_Mode,
  output logic [DATA_W-1:0] oEdit_Value,
  output logic              oWr_Req,
  output logic [3:0]        oWr_Addr,
  output logic [DATA_W-1:0] oWr_Data,
  output logic              oBack
);

  localparam int unsigned       NumItems = MAX_CURSOR_INDEX + 1;
  localparam logic [3:0]        MaxIdx   = 4'(MAX_CURSOR_INDEX);
  localparam logic [DATA_W-1:0] ValMax   = DATA_W'(VAL_MAX);
  localparam logic [DATA_W-1:0] InitVal  = DATA_W'(INIT_VAL);

  typedef enum logic [1:0] {StIdle, StBrowse, StEdit, StCommit} state_e;

  state_e            state_q;
  logic              okay_q, cancel_q;
  logic [3:0]        prev_q, addr_q;
  logic [DATA_W-1:0] bank_q [NumItems];

  logic       okay_edge, cancel_edge;
  logic [3:0] next_up, next_dn;
  logic       step_up, step_dn;

  always_comb begin
    cancel_edge = iOkayCancel[1] & ~cancel_q;
    // Cancel wins over a simultaneous Okay.
    okay_edge   = iOkayCancel[0] & ~okay_q & ~cancel_edge;
    next_up     = (prev_q == MaxIdx) ? 4'd0 : prev_q + 4'd1;
    next_dn     = (prev_q == 4'd0) ? MaxIdx : prev_q - 4'd1;
    step_up     = (iCursor_Index == next_up);
    step_dn     = (iCursor_Index == next_dn);
  end

  always_comb begin
    oDisp_Value = '0;
    if (iDisp_Index <= MaxIdx) oDisp_Value = bank_q[iDisp_Index];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      okay_q      <= 1'b0;
      cancel_q    <= 1'b0;
      prev_q      <= '0;
      addr_q      <= '0;
      bank_q      <= '{default: InitVal};
      oSel_Index  <= '0;
      oEdit_Mode  <= 1'b0;
      oEdit_Value <= '0;
      oWr_Req     <= 1'b0;
      oWr_Addr    <= '0;
      oWr_Data    <= '0;
      oBack       <= 1'b0;
    end else begin
      okay_q   <= iOkayCancel[0];
      cancel_q <= iOkayCancel[1];
      oBack    <= 1'b0;
      if (!en) begin
        state_q     <= StIdle;
        oSel_Index  <= '0;
        oEdit_Mode  <= 1'b0;
        oEdit_Value <= '0;
        oWr_Req     <= 1'b0;
        oWr_Addr    <= '0;
        oWr_Data    <= '0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StBrowse;
          StBrowse: begin
            oSel_Index <= iCursor_Index;
            if (cancel_edge) begin
              oBack <= 1'b1;
            end else if (okay_edge && (iCursor_Index <= MaxIdx)) begin
              addr_q      <= iCursor_Index;
              prev_q      <= iCursor_Index;
              oEdit_Value <= bank_q[iCursor_Index];
              oEdit_Mode  <= 1'b1;
              state_q     <= StEdit;
            end
          end
          StEdit: begin
            prev_q <= iCursor_Index;
            if (cancel_edge) begin
              oEdit_Mode  <= 1'b0;
              oEdit_Value <= '0;
              state_q     <= StBrowse;
            end else if (okay_edge) begin
              if (oEdit_Value == bank_q[addr_q]) begin
                oEdit_Mode  <= 1'b0;
                oEdit_Value <= '0;
                state_q     <= StBrowse;
              end else begin
                oWr_Req  <= 1'b1;
                oWr_Addr <= addr_q;
                oWr_Data <= oEdit_Value;
                state_q  <= StCommit;
              end
            end else if (step_up && (oEdit_Value != ValMax)) begin
              oEdit_Value <= oEdit_Value + 1'b1;
            end else if (step_dn && (oEdit_Value != '0)) begin
              oEdit_Value <= oEdit_Value - 1'b1;
            end
          end
          StCommit: begin
            if (iWr_Ack) begin
              bank_q[addr_q] <= oWr_Data;
              oWr_Req        <= 1'b0;
              oWr_Addr       <= '0;
              oWr_Data       <= '0;
              oEdit_Mode     <= 1'b0;
              oEdit_Value    <= '0;
              state_q        <= StBrowse;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_menu_param_editor.sv
// Self-checking bench for menu_param_editor: directed test-plan scenarios followed by
// randomized cursor/button/ack traffic, all compared against a behavioural model.
module tb_menu_param_editor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] cur = '0;
  logic [1:0] oc = '0;
  logic       ack = 1'b0;
  logic [3:0] disp = '0;
  logic [7:0] disp_val, edit_val, wr_data;
  logic [3:0] sel, wr_addr;
  logic       edit_mode, wr_req, back;

  menu_param_editor dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .iCursor_Index(cur),
    .iOkayCancel  (oc),
    .iWr_Ack      (ack),
    .iDisp_Index  (disp),
    .oDisp_Value  (disp_val),
    .oSel_Index   (sel),
    .oEdit_Mode   (edit_mode),
    .oEdit_Value  (edit_val),
    .oWr_Req      (wr_req),
    .oWr_Addr     (wr_addr),
    .oWr_Data     (wr_data),
    .oBack        (back)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: where the user is in the menu, plus the visible values.
  int  m_mode;  // 0 idle, 1 browsing, 2 editing, 3 waiting for write ack
  int  m_sel, m_val, m_addr, m_prev, m_wdata;
  int  m_bank [11];
  bit  m_req, m_back, m_okp, m_cap;

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_val = 0; m_addr = 0; m_prev = 0; m_wdata = 0;
    m_req = 0; m_back = 0; m_okp = 0; m_cap = 0;
    foreach (m_bank[i]) m_bank[i] = 0;
  endtask

  task automatic model_step();
    bit ok_e, ca_e;
    int c;
    c    = int'(cur);
    ca_e = oc[1] && !m_cap;
    ok_e = oc[0] && !m_okp && !ca_e;
    m_back = 0;
    if (!en) begin
      m_mode = 0; m_sel = 0; m_val = 0; m_req = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          m_sel = c;
          if (ca_e) m_back = 1;
          else if (ok_e && c <= 10) begin
            m_addr = c; m_prev = c; m_val = m_bank[c]; m_mode = 2;
          end
        end
        2: begin
          if (ca_e) begin
            m_mode = 1; m_val = 0;
          end else if (ok_e) begin
            if (m_val == m_bank[m_addr]) begin
              m_mode = 1; m_val = 0;
            end else begin
              m_mode = 3; m_req = 1; m_wdata = m_val;
            end
          end else if (c == (m_prev + 1) % 11) begin
            if (m_val < 255) m_val++;
          end else if (c == (m_prev + 10) % 11) begin
            if (m_val > 0) m_val--;
          end
          m_prev = c;
        end
        default: begin
          if (ack) begin
            m_bank[m_addr] = m_wdata; m_req = 0; m_mode = 1; m_val = 0;
          end
        end
      endcase
    end
    m_okp = oc[0];
    m_cap = oc[1];
  endtask

  task automatic compare_all();
    check("sel", sel, m_sel);
    check("edit_mode", edit_mode, (m_mode >= 2) ? 1 : 0);
    check("edit_val", edit_val, m_val);
    check("wr_req", wr_req, m_req);
    check("wr_addr", wr_addr, m_req ? m_addr : 0);
    check("wr_data", wr_data, m_req ? m_wdata : 0);
    check("back", back, m_back);
    check("disp", disp_val, (disp <= 10) ? m_bank[disp] : 0);
  endtask

  task automatic tick();
    disp = 4'($urandom_range(0, 15));
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();  // no clock edge has occurred since rst rose
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic press_okay();
    oc = 2'b01; tick();
    oc = 2'b00; tick();
  endtask

  task automatic peek_bank(input string tag, input int idx, input int exp);
    disp = 4'(idx);
    #1;
    check(tag, disp_val, exp);
  endtask

  initial begin
    int r;
    model_reset();
    do_reset();

    // Edit item 3 up by two, commit with a delayed ack.
    en = 1; tick();
    for (int i = 1; i <= 3; i++) begin cur = 4'(i); tick(); end
    oc = 2'b01; tick();
    check("t1_sel", sel, 3);
    check("t1_edit_val0", edit_val, 0);
    oc = 2'b00; cur = 4; tick();
    cur = 5; tick();
    check("t1_edit_val2", edit_val, 2);
    oc = 2'b01; tick();
    oc = 2'b00;
    repeat (5) tick();
    check("t1_req_held", wr_req, 1);
    check("t1_data_held", wr_data, 2);
    ack = 1; tick();
    ack = 0; tick();
    peek_bank("t1_bank3", 3, 2);

    // Item 0: wrap-down saturates at 0, wrap-up steps, jump does nothing.
    cur = 0; tick();
    press_okay();
    cur = 10; tick();
    check("t2_sat_low", edit_val, 0);
    cur = 0; tick();
    check("t2_wrap_up", edit_val, 1);
    cur = 1; tick();
    cur = 7; tick();
    check("t2_jump", edit_val, 2);
    oc = 2'b10; tick();
    oc = 2'b00; tick();

    // Commit 254 to item 4, then saturate at 255 and cancel.
    cur = 4; tick();
    press_okay();
    for (int i = 0; i < 254; i++) begin cur = 4'((int'(cur) + 1) % 11); tick(); end
    press_okay();
    ack = 1; tick();
    ack = 0; tick();
    peek_bank("t3_bank4_254", 4, 254);
    cur = 4; tick();
    press_okay();
    for (int i = 0; i < 8; i++) begin cur = 4'((int'(cur) + 1) % 11); tick(); end
    check("t3_sat_high", edit_val, 255);
    oc = 2'b10; tick();
    oc = 2'b00; tick();
    peek_bank("t3_bank4_kept", 4, 254);

    // Net-zero edit, then Cancel and Okay+Cancel in browse.
    press_okay();
    cur = 4'((int'(cur) + 1) % 11); tick();
    cur = 4'((int'(cur) + 10) % 11); tick();
    press_okay();
    check("t4_no_write", wr_req, 0);
    oc = 2'b10; tick();
    check("t4_back", back, 1);
    oc = 2'b00; tick();
    check("t4_back_one", back, 0);
    oc = 2'b11; tick();
    check("t4_both_cancel", back, 1);
    oc = 2'b00; tick();

    // Drop en while a commit is pending.
    cur = 6; tick();
    press_okay();
    cur = 7; tick();
    press_okay();
    tick();
    en = 0; tick();
    check("t5_req_drop", wr_req, 0);
    en = 1; ack = 1; tick();
    ack = 0; tick();
    peek_bank("t5_bank6", 6, 0);

    // Okay held for 20 cycles enters edit once; async reset mid-edit.
    cur = 2; tick();
    oc = 2'b01;
    repeat (20) tick();
    oc = 2'b00; tick();
    do_reset();

    // Randomized traffic.
    en = 1;
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      cur = 4'((int'(cur) + 1) % 11);
      else if (r < 8) cur = 4'((int'(cur) + 10) % 11);
      else if (r == 9) cur = 4'($urandom_range(0, 10));
      oc  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ack = ($urandom_range(0, 3) == 0);
      en  = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/menu_param_editor.md
Name: menu_param_editor

Overview:
- Menu controller directly downstream of the push-button adapter. Consumes its absolute cursor index and its Okay/Cancel button states.
- Holds a bank of NUM_ITEMS editable parameters and runs the browse/edit/commit flow.
- Drives a config write handshake toward the datapath and provides a read port for the TFT menu renderer.

Parameters:
- MAX_CURSOR_INDEX, 10, highest cursor value; must match the adapter; NUM_ITEMS = MAX_CURSOR_INDEX+1.
- DATA_W, 8, width of each parameter.
- VAL_MAX, 255, upper saturation bound of edited values; lower bound is 0.
- INIT_VAL, 0, reset value of every bank entry.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- en  in  1  menu active; same enable as the adapter
- iCursor_Index  in  4  absolute cursor from adapter, 0..MAX_CURSOR_INDEX
- iOkayCancel  in  2  [0]=Okay, [1]=Cancel; button state from adapter (level or pulse)
- iWr_Ack  in  1  datapath accepted the write
- iDisp_Index  in  4  renderer read address
- oDisp_Value  out  DATA_W  bank[iDisp_Index], combinational; 0 if address > MAX_CURSOR_INDEX
- oSel_Index  out  4  highlighted item
- oEdit_Mode  out  1  high in EDIT and COMMIT
- oEdit_Value  out  DATA_W  working value being edited
- oWr_Req  out  1  write request
- oWr_Addr  out  4  write address
- oWr_Data  out  DATA_W  write data
- oBack  out  1  one-cycle pulse: user left the menu (Cancel in BROWSE)

Behaviour:
- Reset: state=IDLE, every output 0, all bank entries = INIT_VAL, edge and previous-cursor registers cleared.
- Okay and Cancel are rising-edge detected internally (registered previous value), so one press is one event regardless of level width. If both edges occur in the same cycle, Cancel wins.
- IDLE: outputs idle. Go to BROWSE on the first cycle with en=1.
- en=0 in any state: go to IDLE next cycle, drop oWr_Req immediately (registered, next edge), discard the working value, leave the bank untouched.
- BROWSE:
  - oSel_Index follows iCursor_Index with 1-cycle latency.
  - Okay edge with iCursor_Index <= MAX_CURSOR_INDEX: latch addr=iCursor_Index, oEdit_Value=bank[addr], prev_cursor=iCursor_Index, go to EDIT.
  - Okay edge with an out-of-range index: ignored.
  - Cancel edge: oBack=1 for exactly one cycle; stay in BROWSE.
- EDIT:
  - oSel_Index is frozen at addr.
  - Each cycle compare iCursor_Index (cur) with prev_cursor (prev):
    - Step +1 when cur == (prev==MAX_CURSOR_INDEX ? 0 : prev+1).
    - Step -1 when cur == (prev==0 ? MAX_CURSOR_INDEX : prev-1).
    - Any other change (jump): no step.
    - prev_cursor <= cur every cycle.
  - Value saturates at VAL_MAX (+1 ignored) and at 0 (-1 ignored). No wrap.
  - Cancel edge: restore nothing to the bank; return to BROWSE.
  - Okay edge, oEdit_Value == bank[addr]: return to BROWSE with no write.
  - Okay edge, value differs: go to COMMIT with oWr_Req=1, oWr_Addr=addr, oWr_Data=oEdit_Value.
- COMMIT:
  - oWr_Req, oWr_Addr and oWr_Data are held stable until iWr_Ack=1 is sampled.
  - On that cycle: bank[addr] <= oWr_Data; oWr_Req drops next cycle; go to BROWSE.
  - An ack present in the same cycle the request is raised is not counted; only acks while oWr_Req=1 count.
  - Okay/Cancel edges in COMMIT are ignored; no abort except en=0 or rst.
- iWr_Ack outside COMMIT: ignored.
- Reset mid-COMMIT: request dropped asynchronously, bank returns to INIT_VAL.
- Renderer read port updates the same cycle a bank entry changes (write-through is not required; the new value is visible from the cycle after the ack).

Test Plan:
- Reset, en=1, cursor 0→3, Okay pulse → EDIT, oSel_Index=3, oEdit_Value=0; cursor 3→4→5 → oEdit_Value=2; Okay → oWr_Req=1, addr=3, data=2 held until ack injected 5 cycles later → bank[3]=2 via oDisp_Value, BROWSE.
- EDIT at item 0 with bank value 0, cursor 0→10 (wrap-down) → step -1 saturates, oEdit_Value stays 0; cursor 10→0 → oEdit_Value=1; cursor 1→7 jump → no step.
- Bank value 254, eight +1 steps → oEdit_Value=255 and held; Cancel → BROWSE, bank unchanged at 254, no oWr_Req ever raised.
- EDIT, net zero steps, Okay → BROWSE with no write request; in BROWSE, Cancel → oBack high exactly one cycle; Okay and Cancel in the same cycle → treated as Cancel.
- COMMIT pending, en dropped for 1 cycle before ack → oWr_Req falls, state IDLE, bank unchanged; re-enable → BROWSE.
- Okay held high 20 cycles → single EDIT entry only; async rst pulse mid-EDIT → all outputs 0 without a clock edge.
